core_exe_pipe: RTL

CORE_EXE_PIPE -- requirements
Module: core_exe_pipe

---
 rtl/core_exe_pipe.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/core_exe_pipe.sv
// core_exe_pipe: execute stage with operand bypass, ALU, branch compare, address adder.
// Define CORE_EXE_MUL_EN to build the radix-2 shift-add multiplier for op 10.
module core_exe_pipe #(
   parameter int XLEN = 32,
   parameter int RAW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            exe_val_in,
   output logic            exe_rdy_out,
   input  logic            exe_kill_in,
   input  logic [3:0]      exe_alu_op_in,
   input  logic [2:0]      exe_alu_cnd_in,
   input  logic            exe_we_in,
   input  logic [RAW-1:0]  exe_rd_in,
   input  logic [XLEN-1:0] exe_src1_in,
   input  logic [XLEN-1:0] exe_src2_in,
   input  logic [XLEN-1:0] exe_pc_in,
   input  logic [XLEN-1:0] exe_imm_in,
   input  logic [1:0]      exe_fwd1_in,
   input  logic [1:0]      exe_fwd2_in,
   input  logic [XLEN-1:0] exe_res_m_in,
   input  logic [XLEN-1:0] exe_res_w_in,
   output logic            exe_val_out_reg,
   output logic            exe_we_out_reg,
   output logic [RAW-1:0]  exe_rd_out_reg,
   output logic            exe_ill_out_reg,
   output logic [XLEN-1:0] exe_res_out_reg,
   output logic [XLEN-1:0] exe_addr_out_reg,
   input  logic            exe_rdy_in,
   output logic            exe_brnch_tknn_out,
   output logic            exe_busy_out
);
   localparam int SHW = $clog2(XLEN);

   logic [XLEN-1:0] w_a, w_b, w_alu, w_addr;
   logic            w_ill, w_acc, w_idle, w_eq, w_lt, w_ltu, w_brn;

   function automatic logic [XLEN-1:0] f_sel(
      input logic [1:0]      f,
      input logic [XLEN-1:0] s
   );
      unique case (f)
         2'b00:   f_sel = s;
         2'b10:   f_sel = exe_res_w_in;
         default: f_sel = exe_res_m_in;
      endcase
   endfunction

   assign w_a    = f_sel(exe_fwd1_in, exe_src1_in);
   assign w_b    = f_sel(exe_fwd2_in, exe_src2_in);
   assign w_addr = exe_imm_in + exe_pc_in;
   assign w_eq   = (w_a == w_b);
   assign w_lt   = ($signed(w_a) < $signed(w_b));
   assign w_ltu  = (w_a < w_b);

   always_comb begin
      w_alu = '0;
      unique case (exe_alu_op_in)
         4'd0:    w_alu = w_a + w_b;
         4'd1:    w_alu = w_a - w_b;
         4'd2:    w_alu = w_a & w_b;
         4'd3:    w_alu = w_a | w_b;
         4'd4:    w_alu = w_a ^ w_b;
         4'd5:    w_alu = w_a << w_b[SHW-1:0];
         4'd6:    w_alu = w_a >> w_b[SHW-1:0];
         4'd7:    w_alu = XLEN'($signed(w_a) >>> w_b[SHW-1:0]);
         4'd8:    w_alu = {{(XLEN-1){1'b0}}, w_lt};
         4'd9:    w_alu = {{(XLEN-1){1'b0}}, w_ltu};
         default: w_alu = '0;
      endcase
   end

   always_comb begin
      w_brn = 1'b0;
      unique case (exe_alu_cnd_in)
         3'd0:    w_brn = w_eq;
         3'd1:    w_brn = !w_eq;
         3'd4:    w_brn = w_lt;
         3'd5:    w_brn = !w_lt;
         3'd6:    w_brn = w_ltu;
         3'd7:    w_brn = !w_ltu;
         default: w_brn = 1'b0;
      endcase
   end

   assign exe_brnch_tknn_out = exe_val_in && w_brn;
   assign exe_rdy_out        = w_idle && (!exe_val_out_reg || exe_rdy_in);
   assign w_acc              = exe_val_in && exe_rdy_out;

`ifdef CORE_EXE_MUL_EN
   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t          r_state;
   logic [SHW-1:0]  r_cnt;
   logic [XLEN-1:0] r_acc, r_mcand, r_mplier, r_maddr;
   logic [RAW-1:0]  r_mrd;
   logic            r_mwe;
   logic [XLEN-1:0] w_acc_nx;
   logic            w_is_mul;

   assign w_idle       = (r_state == S_IDLE);
   assign w_is_mul     = (exe_alu_op_in == 4'd10);
   assign w_ill        = (exe_alu_op_in > 4'd10);
   assign w_acc_nx     = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign exe_busy_out = (r_state == S_MUL);
`else
   assign w_idle       = 1'b1;
   assign w_ill        = (exe_alu_op_in >= 4'd10);
   assign exe_busy_out = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exe_val_out_reg  <= 1'b0;
         exe_we_out_reg   <= 1'b0;
         exe_rd_out_reg   <= '0;
         exe_ill_out_reg  <= 1'b0;
         exe_res_out_reg  <= '0;
         exe_addr_out_reg <= '0;
`ifdef CORE_EXE_MUL_EN
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_maddr  <= '0;
         r_mrd    <= '0;
         r_mwe    <= 1'b0;
`endif
      end else if (exe_kill_in) begin
         exe_val_out_reg <= 1'b0;
`ifdef CORE_EXE_MUL_EN
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
`endif
      end
`ifdef CORE_EXE_MUL_EN
      else if (r_state == S_MUL) begin
         r_acc    <= w_acc_nx;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         // final partial sum goes straight to the output register
         if (r_cnt == SHW'(XLEN-1)) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_acc            <= '0;
            exe_val_out_reg  <= 1'b1;
            exe_we_out_reg   <= r_mwe;
            exe_rd_out_reg   <= r_mrd;
            exe_ill_out_reg  <= 1'b0;
            exe_res_out_reg  <= w_acc_nx;
            exe_addr_out_reg <= r_maddr;
         end
      end else if (w_acc && w_is_mul) begin
         r_state         <= S_MUL;
         r_cnt           <= '0;
         r_acc           <= '0;
         r_mcand         <= w_a;
         r_mplier        <= w_b;
         r_maddr         <= w_addr;
         r_mrd           <= exe_rd_in;
         r_mwe           <= exe_we_in;
         exe_val_out_reg <= 1'b0;
      end
`endif
      else if (w_acc) begin
         exe_val_out_reg  <= 1'b1;
         exe_we_out_reg   <= exe_we_in;
         exe_rd_out_reg   <= exe_rd_in;
         exe_ill_out_reg  <= w_ill;
         exe_res_out_reg  <= w_alu;
         exe_addr_out_reg <= w_addr;
      end else if (exe_val_out_reg && exe_rdy_in) begin
         exe_val_out_reg <= 1'b0;
      end
   end
endmodule
